rr_arbiter: RTL and testbench

- Four-way round-robin request arbiter with grant locking and a hold-timeout.
- Sits directly upstream of the 4-to-2 encoder: its registered one-hot grant vector drives the encoder's 4-bit one-hot input `i`. The encoder/decoder pair then carries the winning requester's index downstream.
- Guarantees the encoder never sees more than one hot bit.

---
 rtl/rr_arbiter.sv | 107 ++++++++++
 tb/tb_rr_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Four-way (parameterisable) round-robin arbiter with grant locking and a hold-timeout.
// The registered one-hot grant feeds a downstream one-hot-to-binary encoder.
module rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 8,
  parameter int CW      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;

  logic          found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic [N-1:0]  win_onehot;
  logic          release_now;

  // Search starts at ptr and wraps; the first set request wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr_q) + i) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = found && (win_idx == PW'(gi));
  end

  assign release_now = ack || (hold_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = win_onehot;
          idx_d      = win_idx;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d     = '0;
          state_d   = IDLE;
          ptr_d     = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
          // ack takes precedence, so a simultaneous expiry is not reported
          timeout_d = !ack;
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed plus randomized bench for rr_arbiter, checked against an integer-level
// model of the arbitration rules (granted index, pointer, cycles held).
module tb_rr_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic [N-1:0] gnt;
  logic         busy;
  logic         timeout;

  rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  // Model: m_idx = granted requester (-1 when idle), m_held = cycles the grant has been visible
  int m_idx = -1;
  int m_ptr = 0;
  int m_held = 0;
  int m_to = 0;
  logic prev_to = 1'b0;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_idx >= 0) g[m_idx] = 1'b1;
    return g;
  endfunction

  function automatic int encode(input logic [N-1:0] g);
    int y;
    y = 0;
    for (int k = 0; k < N; k++) if (g[k]) y = k;
    return y;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic a, input logic rn);
    if (!rn) begin
      m_idx = -1; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (m_idx < 0) begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        if (m_idx < 0 && r[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
      end
      if (m_idx >= 0) m_held = 1;
    end else begin
      m_to = 0;
      if (a || m_held == TIMEOUT) begin
        m_ptr = (m_idx + 1) % N;
        m_to  = a ? 0 : 1;
        m_idx = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic a, input logic rn);
    logic [N-1:0] eg;
    req = r; ack = a; rst_n = rn;
    model_edge(r, a, rn);
    @(posedge clk);
    #1;
    cycle++;
    eg = exp_gnt();
    $display("cyc %0d rst_n=%b req=%b ack=%b -> gnt=%b busy=%b timeout=%b", cycle, rn, r, a, gnt, busy, timeout);
    compared++;
    assert (gnt === eg) else begin
      mismatched++;
      $error("FAIL gnt cyc %0d: observed %b expected %b", cycle, gnt, eg);
    end
    compared++;
    assert (busy === (m_idx >= 0)) else begin
      mismatched++;
      $error("FAIL busy cyc %0d: observed %b expected %b", cycle, busy, (m_idx >= 0));
    end
    compared++;
    assert (timeout === (m_to != 0)) else begin
      mismatched++;
      $error("FAIL timeout cyc %0d: observed %b expected %b", cycle, timeout, (m_to != 0));
    end
    if (m_idx >= 0) begin
      compared++;
      assert (encode(gnt) == m_idx) else begin
        mismatched++;
        $error("FAIL enc_y cyc %0d: observed %0d expected %0d", cycle, encode(gnt), m_idx);
      end
    end
    compared++;
    assert ($countones(gnt) <= 1 && !(prev_to && timeout)) else begin
      mismatched++;
      $error("FAIL invariant cyc %0d: observed gnt=%b timeout=%b prev_timeout=%b required one-hot0 and no double pulse",
             cycle, gnt, timeout, prev_to);
    end
    prev_to = timeout;
  endtask

  initial begin
    // 1: reset then single request, ack after a few cycles
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    // 2: rotation with all requests high, ack one cycle after each grant
    step(4'b0000, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b0, 1'b1);
      step(4'b1111, 1'b1, 1'b1);
    end
    step(4'b0000, 1'b0, 1'b1);
    // 3: priority pointer at 2 with req=0011 wraps to index 0, then ptr=1
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0011, 1'b0, 1'b1);
    step(4'b0011, 1'b1, 1'b1);
    step(4'b0011, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    // 4: timeout with requester 3 and no ack, then re-grant after the bubble
    for (int k = 0; k < 2 * TIMEOUT + 4; k++) step(4'b1000, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    // 5: ack coincides with expiry; req dropped mid-grant keeps the grant
    step(4'b0001, 1'b0, 1'b1);
    for (int k = 0; k < TIMEOUT - 1; k++) step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    // 6: reset mid-grant, then all requests go to index 0
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 6) == 0), ($urandom_range(0, 80) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
